// File: rtl/ysyx_22041207_rx_resp.sv
// Single-outstanding read responder: address handshake, one memory read strobe, latency wait, byte-masked response.
// Optional out-of-window error response enabled by defining YSYX_22041207_RX_RESP_ERR_EN.
module ysyx_22041207_rx_resp #(
  parameter int unsigned LATENCY  = 1,
  parameter logic [63:0] MEM_BASE = 64'h80000000,
  parameter logic [63:0] MEM_SIZE = 64'h08000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_r_valid_i,
  output logic        rx_r_ready_o,
  input  logic [63:0] rx_r_addr_i,
  input  logic [7:0]  rx_r_size_i,
  output logic [63:0] rx_data_read_o,
  output logic        rx_data_valid,
  input  logic        rx_data_ready,
  output logic        rx_resp_err,
  output logic        mem_en,
  output logic [63:0] mem_addr,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WADDR_W  = 61;
  localparam int unsigned BYTES    = 8;
`ifdef YSYX_22041207_RX_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [WADDR_W-1:0] r_word_addr, w_word_addr_nxt;
  logic [7:0]         r_size, w_size_nxt;
  logic [63:0]        r_data, w_data_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_mem_en, w_mem_en_nxt;
  logic               r_err, w_err_nxt;
  logic               w_hs;
  logic               w_oob;
  logic [63:0]        w_masked;

  // Ready is a pure decode of IDLE, forced low while reset is held.
  assign rx_r_ready_o   = rst_n & (r_state == IDLE);
  assign w_hs           = rx_r_valid_i & rx_r_ready_o;
  assign w_oob          = ERR_EN & ((rx_r_addr_i < MEM_BASE) ||
                                    (rx_r_addr_i >= (MEM_BASE + MEM_SIZE)));

  assign rx_data_read_o = r_data;
  assign rx_data_valid  = r_valid;
  assign rx_resp_err    = r_err;
  assign mem_en         = r_mem_en;
  assign mem_addr       = {r_word_addr, 3'b000};

  // Byte-lane mask of the returned word.
  always_comb begin
    w_masked = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_masked[i*8 +: 8] = r_size[i] ? mem_rdata[i*8 +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_word_addr <= '0;
      r_size      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_mem_en    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_word_addr <= w_word_addr_nxt;
      r_size      <= w_size_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_err       <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_word_addr_nxt = r_word_addr;
    w_size_nxt      = r_size;
    w_data_nxt      = r_data;
    w_valid_nxt     = r_valid;
    w_mem_en_nxt    = 1'b0;
    w_err_nxt       = r_err;
    unique case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_word_addr_nxt = rx_r_addr_i[63:3];
          w_size_nxt      = rx_r_size_i;
          if (w_oob) begin
            w_state_nxt = RESP;
            w_data_nxt  = '0;
            w_err_nxt   = 1'b1;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt  = REQ;
            w_mem_en_nxt = 1'b1;
          end
        end
      end
      REQ: begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = CNT_W'(LATENCY);
      end
      WAIT: begin
        // Memory data is valid on the edge where the count has reached 1.
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_data_nxt  = w_masked;
          w_err_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (rx_data_ready) begin
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_err_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041207_rx_resp.sv
// Scoreboard bench for ysyx_22041207_rx_resp: one instance at LATENCY=1, one at LATENCY=4.
module tb_ysyx_22041207_rx_resp;

  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 4;
  localparam logic [63:0] BAD  = 64'hBAD0BAD0BAD0BAD0;

  typedef struct {
    int          inst;
    logic [63:0] data;
    logic        err;
    int          lat;
    logic        memen;
    logic [63:0] maddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_i   [2];
  logic [63:0] a_i   [2];
  logic [7:0]  s_i   [2];
  logic        rdy_o [2];
  logic [63:0] d_o   [2];
  logic        dv    [2];
  logic        dr    [2];
  logic        err   [2];
  logic        men   [2];
  logic [63:0] maddr [2];
  logic [63:0] mrd   [2];
  logic [63:0] mem_word [2];
  logic [3:0]  pv0 = 4'd0;
  logic [3:0]  pv1 = 4'd0;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  bit   spacing_chk = 1'b0;
  int   hs_cyc  [2];
  int   last_hs [2];
  int   men_cnt [2];
  logic prev_dv [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22041207_rx_resp #(.LATENCY(LAT0)) u_l1 (
    .clk(clk), .rst_n(rst_n),
    .rx_r_valid_i(v_i[0]), .rx_r_ready_o(rdy_o[0]), .rx_r_addr_i(a_i[0]), .rx_r_size_i(s_i[0]),
    .rx_data_read_o(d_o[0]), .rx_data_valid(dv[0]), .rx_data_ready(dr[0]), .rx_resp_err(err[0]),
    .mem_en(men[0]), .mem_addr(maddr[0]), .mem_rdata(mrd[0])
  );

  ysyx_22041207_rx_resp #(.LATENCY(LAT1)) u_l4 (
    .clk(clk), .rst_n(rst_n),
    .rx_r_valid_i(v_i[1]), .rx_r_ready_o(rdy_o[1]), .rx_r_addr_i(a_i[1]), .rx_r_size_i(s_i[1]),
    .rx_data_read_o(d_o[1]), .rx_data_valid(dv[1]), .rx_data_ready(dr[1]), .rx_resp_err(err[1]),
    .mem_en(men[1]), .mem_addr(maddr[1]), .mem_rdata(mrd[1])
  );

  // Memory model: data only during the cycle LATENCY cycles after mem_en, garbage otherwise.
  always @(posedge clk) begin
    pv0 <= {pv0[2:0], men[0]};
    pv1 <= {pv1[2:0], men[1]};
  end
  assign mrd[0] = pv0[LAT0-1] ? mem_word[0] : BAD;
  assign mrd[1] = pv1[LAT1-1] ? mem_word[1] : BAD;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  // Monitor: pops the scoreboard on every data beat, checks strobes and hold behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        prev_dv[k] = 1'b0;
        men_cnt[k] = 0;
        last_hs[k] = -1;
        hs_cyc[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!spacing_chk) last_hs[k] = -1;
        if (v_i[k] && rdy_o[k]) begin
          if (spacing_chk && last_hs[k] >= 0)
            chk("hs_spacing", 64'(cyc - last_hs[k]), 64'(lat_of(k) + 3));
          last_hs[k] = cyc;
          hs_cyc[k]  = cyc;
        end
        if (men[k]) begin
          men_cnt[k]++;
          if (q.size() == 0) chk("mem_en_unexpected", 64'(men[k]), 64'd0);
          else chk("mem_addr", maddr[k], q[0].maddr);
        end
        if (dv[k]) begin
          chk("ready_while_busy", 64'(rdy_o[k]), 64'd0);
          if (q.size() == 0) begin
            chk("unexpected_beat", 64'(dv[k]), 64'd0);
          end else begin
            chk("beat_instance", 64'(k), 64'(q[0].inst));
            chk("data", d_o[k], q[0].data);
            chk("err", 64'(err[k]), 64'(q[0].err));
            if (!prev_dv[k]) chk("latency", 64'(cyc - hs_cyc[k]), 64'(q[0].lat));
            if (dr[k]) begin
              chk("mem_en_count", 64'(men_cnt[k]), 64'(q[0].memen));
              men_cnt[k] = 0;
              void'(q.pop_front());
            end
          end
        end
        prev_dv[k] = dv[k];
      end
    end
  end

  task automatic push(input int k, input logic [63:0] data, input logic e, input int lat,
                      input logic memen, input logic [63:0] ma);
    exp_t x;
    x.inst = k; x.data = data; x.err = e; x.lat = lat; x.memen = memen; x.maddr = ma;
    q.push_back(x);
  endtask

  task automatic wait_hs(input int k);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (rdy_o[k]) break;
      n++;
      if (n > 50) begin chk("hs_timeout", 64'(rdy_o[k]), 64'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (q.size() == 0 && rdy_o[k]) break;
      n++;
      if (n > 100) begin chk("drain_timeout", 64'(q.size()), 64'd0); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int k, input logic [63:0] addr, input logic [7:0] size,
                      input logic [63:0] word, input logic [63:0] exp_d, input logic exp_e,
                      input int exp_lat, input logic exp_men, input logic [63:0] exp_ma,
                      input bit hold);
    mem_word[k] = word;
    a_i[k] = addr;
    s_i[k] = size;
    v_i[k] = 1'b1;
    push(k, exp_d, exp_e, exp_lat, exp_men, exp_ma);
    wait_hs(k);
    if (!hold) v_i[k] = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_ready"}, 64'(rdy_o[k]), 64'd0);
    chk({tag, "_valid"}, 64'(dv[k]), 64'd0);
    chk({tag, "_data"}, d_o[k], 64'd0);
    chk({tag, "_err"}, 64'(err[k]), 64'd0);
    chk({tag, "_mem_en"}, 64'(men[k]), 64'd0);
    chk({tag, "_mem_addr"}, maddr[k], 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v_i[k] = 1'b0; a_i[k] = '0; s_i[k] = '0; dr[k] = 1'b1; mem_word[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset0", 64'(rdy_o[0]), 64'd1);
    chk("ready_after_reset1", 64'(rdy_o[1]), 64'd1);
    @(posedge clk); #1;

    // LATENCY=1: basic, sparse mask, empty mask, unaligned address
    send(0, 64'h80000004, 8'h0F, 64'h1122334455667788, 64'h0000000055667788, 1'b0, 3, 1'b1, 64'h80000000, 1'b0);
    wait_idle(0);
    send(0, 64'h80000010, 8'hA5, 64'h1122334455667788, 64'h1100330000660088, 1'b0, 3, 1'b1, 64'h80000010, 1'b0);
    wait_idle(0);
    send(0, 64'h80000020, 8'h00, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000000, 1'b0, 3, 1'b1, 64'h80000020, 1'b0);
    wait_idle(0);
    send(0, 64'h80000007, 8'hF0, 64'hCAFEBABEDEADBEEF, 64'hCAFEBABE00000000, 1'b0, 3, 1'b1, 64'h80000000, 1'b0);
    wait_idle(0);

    // Request held through a transaction: re-accepted on the first IDLE cycle
    spacing_chk = 1'b1;
    send(0, 64'h80000008, 8'hFF, 64'h0F0E0D0C0B0A0908, 64'h0F0E0D0C0B0A0908, 1'b0, 3, 1'b1, 64'h80000008, 1'b1);
    push(0, 64'h0F0E0D0C0B0A0908, 1'b0, 3, 1'b1, 64'h80000008);
    wait_hs(0);
    v_i[0] = 1'b0;
    spacing_chk = 1'b0;
    wait_idle(0);

    // Out-of-window address, then an in-window read
`ifdef YSYX_22041207_RX_RESP_ERR_EN
    send(0, 64'h00001000, 8'hFF, 64'h5555AAAA5555AAAA, 64'h0000000000000000, 1'b1, 1, 1'b0, 64'h0, 1'b0);
`else
    send(0, 64'h00001000, 8'hFF, 64'h5555AAAA5555AAAA, 64'h5555AAAA5555AAAA, 1'b0, 3, 1'b1, 64'h00001000, 1'b0);
`endif
    wait_idle(0);
    send(0, 64'h80000100, 8'h3C, 64'h1122334455667788, 64'h0000334455660000, 1'b0, 3, 1'b1, 64'h80000100, 1'b0);
    wait_idle(0);

    // LATENCY=4: full mask
    send(1, 64'h80000000, 8'hFF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 6, 1'b1, 64'h80000000, 1'b0);
    wait_idle(1);

    // Backpressure: ready low for 5 cycles in RESP
    dr[1] = 1'b0;
    send(1, 64'h80000048, 8'hF0, 64'h8877665544332211, 64'h8877665500000000, 1'b0, 6, 1'b1, 64'h80000048, 1'b0);
    begin
      int n = 0;
      while (!dv[1] && n < 50) begin @(posedge clk); #1; n++; end
      chk("bp_valid_seen", 64'(dv[1]), 64'd1);
    end
    repeat (5) @(posedge clk);
    #1;
    dr[1] = 1'b1;
    wait_idle(1);

    // Reset while in WAIT aborts the transaction
    send(1, 64'h80000040, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 1'b0, 6, 1'b1, 64'h80000040, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_zero(1, "midreset");
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_midreset", 64'(rdy_o[1]), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("no_beat_after_abort", 64'(dv[1]), 64'd0);

    send(1, 64'h80000018, 8'h0F, 64'hDEADBEEFFEEDFACE, 64'h00000000FEEDFACE, 1'b0, 6, 1'b1, 64'h80000018, 1'b0);
    wait_idle(1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
